// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, one-hot status values, register sentinel
// and the pipeline controller state encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    // Status is one-hot {HLT, INS, AOK}
    localparam logic [2:0] STAT_AOK = 3'b001;
    localparam logic [2:0] STAT_INS = 3'b010;
    localparam logic [2:0] STAT_HLT = 3'b100;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc unless hold is high, sticks at all-ones.
module sat_counter
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !hold && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline hazard controller: stall/bubble generation, exception drain/halt FSM
// and saturating performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       m_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       w_icode,
    input  logic [2:0]       w_stat,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] rtr_cnt
);

    state_e state_q;
    state_e state_d;
    logic   halted_q;
    logic   halted_d;

    logic lu;
    logic mp;
    logic rp;
    logic retire;
    logic hold;

    always_comb begin
        lu = is_mem_load(e_icode) && (e_dstM != REG_NONE) &&
             ((e_dstM == d_srcA) || (e_dstM == d_srcB));
        mp = (e_icode == I_JXX) && !e_cnd;
        rp = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
        retire = (w_stat == STAT_AOK) && (w_icode != I_NOP);
        hold   = (state_q == S_HALTED);
    end

    // Load-use wins over ret: the decode slot is held rather than bubbled.
    always_comb begin
        f_stall  = lu | rp;
        d_stall  = lu;
        d_bubble = mp | (rp & ~lu);
        e_bubble = mp | lu;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        case (state_q)
            S_RUN:   ;
            S_DRAIN: m_bubble = 1'b1;
            default: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                d_bubble = 1'b0;
                e_bubble = 1'b0;
                m_bubble = 1'b0;
                w_stall  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (w_stat != STAT_AOK) begin
                    state_d = S_HALTED;
                end else if (m_stat != STAT_AOK) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_stat != STAT_AOK) begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_HALTED;
        endcase
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign state  = state_q;
    assign halted = halted_q;

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst(rst), .inc(1'b1), .hold(hold), .count(cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk(clk), .rst(rst), .inc(lu), .hold(hold), .count(lu_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk(clk), .rst(rst), .inc(mp), .hold(hold), .count(mp_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk(clk), .rst(rst), .inc(rp & ~lu), .hold(hold), .count(ret_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rtr_cnt (
        .clk(clk), .rst(rst), .inc(retire), .hold(hold), .count(rtr_cnt)
    );

endmodule
